// File: rtl/sdr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdr_arbiter_pkg
// Shared definitions for the two-port SDRAM user-port arbiter:
//   - state_e      : 2-bit FSM encoding (IDLE, HOLD, RD_WAIT)
//   - ID_W / id_t  : requester id width and type
//   - CNT_W        : read-timeout counter width (timeouts up to 1023 cycles)
//   - ERR_DATA_DEF : default data returned for a timed-out read
// -----------------------------------------------------------------------------
package sdr_arbiter_pkg;

    localparam int ID_W  = 1;
    localparam int CNT_W = 10;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdr_arb_rr2.sv
// -----------------------------------------------------------------------------
// sdr_arb_rr2
// Combinational two-requester winner selection.
//   RR_EN = 1 : on a tie, the requester that was NOT granted last wins.
//   RR_EN = 0 : on a tie, requester 0 always wins.
// Ports:
//   req_i   [1:0] in   request vector, bit N = requester N
//   last_i        in   id of the most recent grant
//   valid_o       out  at least one request is present
//   gnt_o         out  id of the winner (meaningful only when valid_o = 1)
// -----------------------------------------------------------------------------
module sdr_arb_rr2
    import sdr_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_i,
    input  id_t        last_i,
    output logic       valid_o,
    output id_t        gnt_o
);

    always_comb begin
        valid_o = |req_i;
        gnt_o   = '0;
        if (req_i[0] && req_i[1]) begin
            gnt_o = RR_EN ? ~last_i : id_t'(0);
        end else if (req_i[1]) begin
            gnt_o = id_t'(1);
        end
    end

endmodule

// File: rtl/sdr_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_arbiter
// Arbitrates two requesters onto one SDRAM controller user port. One
// transaction is outstanding at a time; reads wait for the controller's
// return (or a timeout) and the data is routed back to the owner.
// Every output is driven straight from a register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mN_req/rw/addr/wdata      requester N command (held until mN_ack)
//   mN_ack                    one-cycle accept/issue pulse
//   mN_rvalid/rdata/rerr      read return; rerr marks a timed-out read
//   sdr_addr/rw/wdata         registered command to the controller
//   sdr_in_valid              one-cycle issue pulse to the controller
//   sdr_busy                  controller cannot accept a command
//   sdr_out_valid/rdata       controller read return
// RD_TIMEOUT must lie in 4..1023.
// -----------------------------------------------------------------------------
module sdr_arbiter
    import sdr_arbiter_pkg::*;
#(
    parameter bit          RR_EN      = 1'b1,
    parameter int          RD_TIMEOUT = 64,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [22:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rerr,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [22:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rerr,
    output logic [22:0] sdr_addr,
    output logic        sdr_rw,
    output logic [31:0] sdr_wdata,
    output logic        sdr_in_valid,
    input  logic        sdr_busy,
    input  logic        sdr_out_valid,
    input  logic [31:0] sdr_rdata
);

    // The counter starts at RD_TIMEOUT-1 and times out on the cycle it reads
    // zero, so the owner is answered after exactly RD_TIMEOUT RD_WAIT cycles.
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(RD_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              hold_first_q, hold_first_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    id_t               owner_q, owner_d;
    id_t               last_q, last_d;
    logic              in_valid_q, in_valid_d;
    logic [22:0]       addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        rerr_q, rerr_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic              gnt_valid;
    id_t               gnt_id;
    logic [31:0]       ret_data;

    sdr_arb_rr2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .valid_o (gnt_valid),
        .gnt_o   (gnt_id)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        hold_first_d = 1'b0;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        in_valid_d   = 1'b0;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        ack_d        = '0;
        rvalid_d     = '0;
        rerr_d       = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ret_data     = '0;

        case (state_q)
            ST_IDLE: begin
                if (!sdr_busy && gnt_valid) begin
                    in_valid_d     = 1'b1;
                    ack_d[gnt_id]  = 1'b1;
                    last_d         = gnt_id;
                    owner_d        = gnt_id;
                    if (gnt_id == id_t'(1)) begin
                        rw_d    = m1_rw;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        rw_d    = m0_rw;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                    if (rw_d) begin
                        state_d      = ST_HOLD;
                        hold_first_d = 1'b1;
                    end else begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = TO_LOAD;
                    end
                end
            end

            // The first HOLD cycle is unconditional: the controller raises
            // sdr_busy one cycle after seeing sdr_in_valid, so busy is not
            // trustworthy until the second cycle.
            ST_HOLD: begin
                if (!hold_first_q && !sdr_busy) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                if (sdr_out_valid || cnt_q == '0) begin
                    ret_data        = sdr_out_valid ? sdr_rdata : ERR_DATA;
                    rvalid_d[owner_q] = 1'b1;
                    rerr_d[owner_q]   = !sdr_out_valid;
                    if (owner_q == id_t'(1)) begin
                        rdata1_d = ret_data;
                    end else begin
                        rdata0_d = ret_data;
                    end
                    state_d      = ST_HOLD;
                    hold_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_first_q <= 1'b0;
            cnt_q        <= '0;
            owner_q      <= '0;
            last_q       <= '0;
            in_valid_q   <= 1'b0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            ack_q        <= '0;
            rvalid_q     <= '0;
            rerr_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_first_q <= hold_first_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            in_valid_q   <= in_valid_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            rvalid_q     <= rvalid_d;
            rerr_q       <= rerr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign sdr_in_valid = in_valid_q;
    assign sdr_addr     = addr_q;
    assign sdr_rw       = rw_q;
    assign sdr_wdata    = wdata_q;
    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_rvalid    = rvalid_q[0];
    assign m1_rvalid    = rvalid_q[1];
    assign m0_rerr      = rerr_q[0];
    assign m1_rerr      = rerr_q[1];
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;

endmodule

// File: tb/tb_sdr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdr_arbiter
// Two arbiter instances share clk/rst: instance 0 is round-robin, instance 1
// is fixed priority; both use an 8-cycle read timeout. Directed stimulus
// pushes the expected issues and read returns into per-instance queues; a
// negedge monitor pops and compares whenever an instance shows sdr_in_valid
// or mN_rvalid.
// -----------------------------------------------------------------------------
module tb_sdr_arbiter;

    typedef struct packed {
        logic        id;
        logic        rw;
        logic [22:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        rerr;
        int          cyc;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        m_req    [2][2];
    logic        m_rw     [2][2];
    logic [22:0] m_addr   [2][2];
    logic [31:0] m_wdata  [2][2];
    logic        m_ack    [2][2];
    logic        m_rvalid [2][2];
    logic [31:0] m_rdata  [2][2];
    logic        m_rerr   [2][2];
    logic [22:0] s_addr      [2];
    logic        s_rw        [2];
    logic [31:0] s_wdata     [2];
    logic        s_in_valid  [2];
    logic        s_busy      [2];
    logic        s_out_valid [2];
    logic [31:0] s_rdata     [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_iss [2] = '{-100, -100};
    iss_t iss_q0[$];
    iss_t iss_q1[$];
    rsp_t rsp_q0[$];
    rsp_t rsp_q1[$];

    logic        p_req [2][2];
    logic [55:0] p_cmd [2][2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdr_arbiter #(
            .RR_EN      (1'(g == 0)),
            .RD_TIMEOUT (8),
            .ERR_DATA   (32'hDEAD_BEEF)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .m0_req        (m_req[g][0]),
            .m0_rw         (m_rw[g][0]),
            .m0_addr       (m_addr[g][0]),
            .m0_wdata      (m_wdata[g][0]),
            .m0_ack        (m_ack[g][0]),
            .m0_rvalid     (m_rvalid[g][0]),
            .m0_rdata      (m_rdata[g][0]),
            .m0_rerr       (m_rerr[g][0]),
            .m1_req        (m_req[g][1]),
            .m1_rw         (m_rw[g][1]),
            .m1_addr       (m_addr[g][1]),
            .m1_wdata      (m_wdata[g][1]),
            .m1_ack        (m_ack[g][1]),
            .m1_rvalid     (m_rvalid[g][1]),
            .m1_rdata      (m_rdata[g][1]),
            .m1_rerr       (m_rerr[g][1]),
            .sdr_addr      (s_addr[g]),
            .sdr_rw        (s_rw[g]),
            .sdr_wdata     (s_wdata[g]),
            .sdr_in_valid  (s_in_valid[g]),
            .sdr_busy      (s_busy[g]),
            .sdr_out_valid (s_out_valid[g]),
            .sdr_rdata     (s_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic iss_t mk_iss(input logic id, input logic rw, input logic [22:0] a, input logic [31:0] w);
        iss_t e;
        e.id = id; e.rw = rw; e.addr = a; e.wdata = w;
        return e;
    endfunction

    function automatic rsp_t mk_rsp(input logic id, input logic [31:0] d, input logic err, input int c);
        rsp_t r;
        r.id = id; r.rdata = d; r.rerr = err; r.cyc = c;
        return r;
    endfunction

    function automatic void push_iss(input int d, input iss_t e);
        if (d == 0) iss_q0.push_back(e); else iss_q1.push_back(e);
    endfunction

    function automatic void push_rsp(input int d, input rsp_t r);
        if (d == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
    endfunction

    function automatic int iss_n(input int d);
        return (d == 0) ? iss_q0.size() : iss_q1.size();
    endfunction

    function automatic int rsp_n(input int d);
        return (d == 0) ? rsp_q0.size() : rsp_q1.size();
    endfunction

    // Scoreboard monitor for one instance, run on every falling edge.
    task automatic monitor_dut(input int d);
        iss_t e;
        rsp_t r;
        if (s_in_valid[d]) begin
            if (iss_n(d) == 0) begin
                check($sformatf("d%0d_unexpected_issue", d), 64'(s_in_valid[d]), 64'd0);
            end else begin
                e = (d == 0) ? iss_q0.pop_front() : iss_q1.pop_front();
                check($sformatf("d%0d_ack_winner_m%0d", d, e.id), 64'(m_ack[d][e.id]), 64'd1);
                check($sformatf("d%0d_ack_loser", d), 64'(m_ack[d][!e.id]), 64'd0);
                check($sformatf("d%0d_issue_cmd", d), 64'({s_rw[d], s_addr[d], s_wdata[d]}),
                      64'({e.rw, e.addr, e.wdata}));
                check($sformatf("d%0d_issue_spacing", d), 64'(cyc - last_iss[d] >= 2), 64'd1);
            end
            last_iss[d] <= cyc;
        end else if (m_ack[d][0] || m_ack[d][1]) begin
            check($sformatf("d%0d_ack_without_issue", d), 64'({m_ack[d][1], m_ack[d][0]}), 64'd0);
        end
        for (int m = 0; m < 2; m++) begin
            if (m_rvalid[d][m]) begin
                if (rsp_n(d) == 0) begin
                    check($sformatf("d%0d_m%0d_unexpected_rvalid", d, m), 64'(m_rvalid[d][m]), 64'd0);
                end else begin
                    r = (d == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
                    check($sformatf("d%0d_rsp_owner_err_data", d), 64'({1'(m), m_rerr[d][m], m_rdata[d][m]}),
                          64'({r.id, r.rerr, r.rdata}));
                    check($sformatf("d%0d_rsp_cycle", d), 64'(cyc), 64'(r.cyc));
                end
            end else if (m_rerr[d][m]) begin
                check($sformatf("d%0d_m%0d_rerr_without_rvalid", d, m), 64'(m_rerr[d][m]), 64'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor_dut(d);
    end

    // Requester protocol: command must stay stable while req=1 until ack.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (p_req[d][m] && m_req[d][m] && !m_ack[d][m])
                    assert ({m_rw[d][m], m_addr[d][m], m_wdata[d][m]} == p_cmd[d][m])
                    else $error("protocol: command changed before ack d%0d m%0d", d, m);
                p_req[d][m] <= m_req[d][m];
                p_cmd[d][m] <= {m_rw[d][m], m_addr[d][m], m_wdata[d][m]};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int d, input int m, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (m_ack[d][m]) return;
        end
        check($sformatf("d%0d_m%0d_ack_timeout", d, m), 64'(m_ack[d][m]), 64'd1);
        m_req[d][m] = 1'b0;
    endtask

    task automatic master_seq(input int d, input int m, input logic rw, input logic [22:0] abase,
                              input logic [31:0] wbase, input int n);
        for (int k = 0; k < n; k++) begin
            m_req[d][m]   = 1'b1;
            m_rw[d][m]    = rw;
            m_addr[d][m]  = abase + 23'(k);
            m_wdata[d][m] = wbase + 32'(k);
            wait_ack(d, m, 100);
        end
        m_req[d][m] = 1'b0;
    endtask

    // Controller model: answers each read issue after 'delay' cycles.
    task automatic ctrl_reads(input int d, input int n, input int delay, input logic [7:0] id_seq,
                              input logic [31:0] dbase);
        int i;
        for (int t = 0; t < n; t++) begin
            i = 0;
            while (!s_in_valid[d] && i < 100) begin
                tick();
                i++;
            end
            if (i == 100) check($sformatf("d%0d_ctrl_issue_timeout", d), 64'(s_in_valid[d]), 64'd1);
            repeat (delay) tick();
            s_out_valid[d] = 1'b1;
            s_rdata[d]     = dbase + 32'(t);
            push_rsp(d, mk_rsp(id_seq[t], dbase + 32'(t), 1'b0, cyc + 1));
            tick();
            s_out_valid[d] = 1'b0;
            s_rdata[d]     = '0;
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check($sformatf("%s_d%0d_sdr", tag, d), 64'({s_in_valid[d], s_rw[d], s_addr[d], s_wdata[d]}), 64'd0);
        for (int m = 0; m < 2; m++)
            check($sformatf("%s_d%0d_m%0d", tag, d, m),
                  64'({m_ack[d][m], m_rvalid[d][m], m_rerr[d][m], m_rdata[d][m]}), 64'd0);
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_busy[d] = 1'b0; s_out_valid[d] = 1'b0; s_rdata[d] = '0;
            for (int m = 0; m < 2; m++) begin
                m_req[d][m] = 1'b0; m_rw[d][m] = 1'b0; m_addr[d][m] = '0; m_wdata[d][m] = '0;
            end
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs(0, "reset");
        check_reset_outputs(1, "reset");

        // Round-robin tie: pointer is 0 after reset, so m1, m0, m1, m0.
        push_iss(0, mk_iss(1'b1, 1'b0, 23'h000200, 32'h0));
        push_iss(0, mk_iss(1'b0, 1'b0, 23'h000100, 32'h0));
        push_iss(0, mk_iss(1'b1, 1'b0, 23'h000201, 32'h1));
        push_iss(0, mk_iss(1'b0, 1'b0, 23'h000101, 32'h1));
        fork
            master_seq(0, 0, 1'b0, 23'h000100, 32'h0, 2);
            master_seq(0, 1, 1'b0, 23'h000200, 32'h0, 2);
            ctrl_reads(0, 4, 2, 8'b0000_0101, 32'hC0DE_0000);
        join
        repeat (4) tick();

        // Single write from m0.
        push_iss(0, mk_iss(1'b0, 1'b1, 23'h000100, 32'h1234_5678));
        master_seq(0, 0, 1'b1, 23'h000100, 32'h1234_5678, 1);
        repeat (4) tick();

        // m1 read answered five cycles after issue.
        push_iss(0, mk_iss(1'b1, 1'b0, 23'h000104, 32'h0));
        m_req[0][1] = 1'b1; m_rw[0][1] = 1'b0; m_addr[0][1] = 23'h000104; m_wdata[0][1] = '0;
        wait_ack(0, 1, 50);
        m_req[0][1] = 1'b0;
        repeat (5) tick();
        s_out_valid[0] = 1'b1;
        s_rdata[0]     = 32'hCAFE_0001;
        push_rsp(0, mk_rsp(1'b1, 32'hCAFE_0001, 1'b0, cyc + 1));
        tick();
        s_out_valid[0] = 1'b0;
        s_rdata[0]     = '0;
        repeat (5) tick();
        check("m1_rdata_hold", 64'(m_rdata[0][1]), 64'(32'hCAFE_0001));

        // sdr_busy blocks issue in IDLE and extends HOLD.
        s_busy[0] = 1'b1;
        m_req[0][0] = 1'b1; m_rw[0][0] = 1'b1; m_addr[0][0] = 23'h000110; m_wdata[0][0] = 32'hAAAA_0001;
        repeat (4) tick();
        push_iss(0, mk_iss(1'b0, 1'b1, 23'h000110, 32'hAAAA_0001));
        s_busy[0] = 1'b0;
        wait_ack(0, 0, 50);
        m_req[0][0] = 1'b0;
        s_busy[0] = 1'b1;
        m_req[0][1] = 1'b1; m_rw[0][1] = 1'b1; m_addr[0][1] = 23'h000114; m_wdata[0][1] = 32'hBBBB_0002;
        repeat (4) tick();
        push_iss(0, mk_iss(1'b1, 1'b1, 23'h000114, 32'hBBBB_0002));
        s_busy[0] = 1'b0;
        wait_ack(0, 1, 50);
        m_req[0][1] = 1'b0;
        repeat (4) tick();

        // Read timeout after 8 RD_WAIT cycles; later out_valid in HOLD and IDLE ignored.
        push_iss(0, mk_iss(1'b0, 1'b0, 23'h000108, 32'h0));
        m_req[0][0] = 1'b1; m_rw[0][0] = 1'b0; m_addr[0][0] = 23'h000108; m_wdata[0][0] = '0;
        wait_ack(0, 0, 50);
        m_req[0][0] = 1'b0;
        c0 = cyc;
        push_rsp(0, mk_rsp(1'b0, 32'hDEAD_BEEF, 1'b1, c0 + 8));
        repeat (8) tick();
        s_out_valid[0] = 1'b1; s_rdata[0] = 32'h0BAD_0001;
        tick();
        s_out_valid[0] = 1'b0;
        repeat (4) tick();
        s_out_valid[0] = 1'b1; s_rdata[0] = 32'h0BAD_0002;
        tick();
        s_out_valid[0] = 1'b0; s_rdata[0] = '0;
        repeat (3) tick();
        check("m0_rdata_after_timeout", 64'(m_rdata[0][0]), 64'(32'hDEAD_BEEF));

        // Fixed priority: m0 wins every tie, m1 only after m0 drops.
        push_iss(1, mk_iss(1'b0, 1'b1, 23'h000300, 32'h1111_0000));
        push_iss(1, mk_iss(1'b0, 1'b1, 23'h000301, 32'h1111_0001));
        push_iss(1, mk_iss(1'b0, 1'b1, 23'h000302, 32'h1111_0002));
        push_iss(1, mk_iss(1'b1, 1'b1, 23'h000400, 32'h2222_0000));
        fork
            master_seq(1, 0, 1'b1, 23'h000300, 32'h1111_0000, 3);
            master_seq(1, 1, 1'b1, 23'h000400, 32'h2222_0000, 1);
        join
        repeat (4) tick();

        // Reset during RD_WAIT abandons the read; late out_valid ignored.
        push_iss(0, mk_iss(1'b0, 1'b0, 23'h00010C, 32'h0));
        m_req[0][0] = 1'b1; m_rw[0][0] = 1'b0; m_addr[0][0] = 23'h00010C; m_wdata[0][0] = '0;
        wait_ack(0, 0, 50);
        m_req[0][0] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        s_out_valid[0] = 1'b1; s_rdata[0] = 32'h5555_AAAA;
        tick();
        s_out_valid[0] = 1'b0; s_rdata[0] = '0;
        repeat (4) tick();
        check_reset_outputs(0, "abandon");
        check_reset_outputs(1, "abandon");

        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_issues_left", d), 64'(iss_n(d)), 64'd0);
            check($sformatf("d%0d_responses_left", d), 64'(rsp_n(d)), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_arbiter.md
SDR_ARBITER -- requirements
Module: sdr_arbiter

Interface
REQ-001 Parameter RR_EN, 1, 1 = round-robin between requesters, 0 = fixed priority to m0.
REQ-002 Parameter RD_TIMEOUT, 64, maximum cycles to wait for sdr_out_valid after a read issue (legal range 4..1023).
REQ-003 Parameter ERR_DATA, 32'hDEAD_BEEF, read data returned when a read times out.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mN_req  in  1  requester N (N=0,1) transaction request; held high with stable rw/addr/wdata until mN_ack.
REQ-007 mN_rw  in  1  1 = write, 0 = read.
REQ-008 mN_addr  in  23  word address in user address space.
REQ-009 mN_wdata  in  32  write data.
REQ-010 mN_ack  out  1  one-cycle pulse; request accepted and issued.
REQ-011 mN_rvalid  out  1  one-cycle pulse; mN_rdata valid.
REQ-012 mN_rdata  out  32  read data, or ERR_DATA on timeout.
REQ-013 mN_rerr  out  1  coincident with mN_rvalid; 1 = timed-out read.
REQ-014 sdr_addr  out  23, sdr_rw  out  1, sdr_wdata  out  32: registered command to the SDRAM controller user port.
REQ-015 sdr_in_valid  out  1  one-cycle issue pulse.
REQ-016 sdr_busy  in  1; sdr_out_valid  in  1; sdr_rdata  in  32: controller status and read return.

Function
REQ-017 States: IDLE, HOLD, RD_WAIT; IDLE after reset.
REQ-018 Issue occurs only in IDLE with sdr_busy=0 and at least one mN_req=1.
REQ-019 On issue: sdr_in_valid=1, sdr_addr/rw/wdata = winner's values, winner's mN_ack=1, all in the same cycle; the loser sees no ack.
REQ-020 Arbitration, RR_EN=1: single requester wins; both requesting -> the requester NOT granted last wins; the last-grant pointer is 0 after reset, so m1 wins the first tie.
REQ-021 Arbitration, RR_EN=0: m0 always wins a tie.
REQ-022 Write issue -> HOLD; HOLD lasts at least one cycle and exits to IDLE on the first cycle sdr_busy=0 after that minimum (covers the controller's one-cycle busy assertion delay).
REQ-023 Read issue -> RD_WAIT; owner id and RD_TIMEOUT counter are latched.
REQ-024 RD_WAIT: on sdr_out_valid=1, the owner's mN_rdata=sdr_rdata and mN_rvalid=1 on the next cycle, mN_rerr=0; then -> HOLD.
REQ-025 RD_WAIT: the counter decrements each cycle; at 0 without sdr_out_valid, the owner gets rvalid=1, rerr=1, rdata=ERR_DATA; then -> HOLD.
REQ-026 sdr_out_valid in IDLE or HOLD is ignored; no rvalid is generated.
REQ-027 At most one transaction is outstanding; minimum issue spacing is 2 cycles.
REQ-028 mN_rdata holds its last value between rvalid pulses.
REQ-029 A request dropped before ack has no effect; changing rw/addr/wdata while req=1 and before ack is a protocol violation (bench assertion).

Reset
REQ-030 On rst: state=IDLE; sdr_in_valid, all mN_ack, mN_rvalid, mN_rerr = 0; sdr_addr, sdr_wdata, mN_rdata = 0; sdr_rw = 0; last-grant pointer = 0; timeout counter = 0.
REQ-031 Reset mid-transaction abandons it: no rvalid is ever produced for the abandoned read, and a late sdr_out_valid is ignored.

Structure
REQ-032 Shared package holds the state encoding (2-bit), the requester-id width, and the ERR_DATA default.
REQ-033 The round-robin/priority selection is one sub-module, sdr_arb_rr2 (combinational winner from requests, pointer, and RR_EN).
REQ-034 All outputs are registered; no combinational path from any input to any output.

Verification
REQ-035 m0 write addr=23'h000100, wdata=32'h1234_5678 -> one sdr_in_valid with sdr_rw=1 and those values; m0_ack in the same cycle; no m0_rvalid.
REQ-036 m1 read addr=23'h000104, controller returns 32'hCAFE_0001 five cycles later -> m1_rvalid one cycle after sdr_out_valid, m1_rdata=32'hCAFE_0001, m1_rerr=0.
REQ-037 RR_EN=1, both requesting reads continuously for 4 transactions -> grant order m1, m0, m1, m0; each issue separated by at least 2 cycles.
REQ-038 RR_EN=0, both requesting -> m0 granted every time while m0_req=1; m1 granted only after m0_req drops.
REQ-039 Read with RD_TIMEOUT=8 and no sdr_out_valid -> after 8 RD_WAIT cycles, m0_rvalid=1, m0_rerr=1, m0_rdata=32'hDEAD_BEEF; a later spurious sdr_out_valid is ignored.
REQ-040 rst asserted while in RD_WAIT, sdr_out_valid pulsed 2 cycles after rst deasserts -> no rvalid on either port; all outputs equal their reset values.
